parking_entry_gate: RTL and testbench

//  Entry-barrier controller that sits directly upstream of parking_system.
//  - Debounces the raw entry-lane sensor and checks available_slots.
//  - Issues the single-cycle car_arrival pulse to parking_system.
//  - Drives the barrier, then waits for the car to clear the lane so one car is counted once.

---
 rtl/parking_entry_gate_if.sv | 39 +++
 rtl/parking_entry_gate.sv | 168 ++++++++++++++++
 tb/tb_parking_entry_gate.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/parking_entry_gate_if.sv
// Lane-side bundle between the entry gate controller and the lane sensors / parking_system.
// Latency: none, wires only.
// Backpressure: none; sensors are level signals and car_arrival is a fire-and-forget pulse.
interface parking_entry_gate_if #(
  parameter int CNT_W = 8
);
  logic             entry_sensor;
  logic             pass_sensor;
  logic [2:0]       available_slots;
  logic             car_arrival;
  logic             gate_open;
  logic             full_lamp;
  logic             entry_timeout;
  logic [CNT_W-1:0] cars_entered;

  // Lane / parking_system side: drives sensors and slot count, observes the gate.
  modport master (
    output entry_sensor,
    output pass_sensor,
    output available_slots,
    input  car_arrival,
    input  gate_open,
    input  full_lamp,
    input  entry_timeout,
    input  cars_entered
  );

  // Gate controller side.
  modport slave (
    input  entry_sensor,
    input  pass_sensor,
    input  available_slots,
    output car_arrival,
    output gate_open,
    output full_lamp,
    output entry_timeout,
    output cars_entered
  );
endinterface

// File: rtl/parking_entry_gate.sv
// Entry-barrier controller: debounces the lane sensor, requests a slot, opens the gate until the car passes.
// Latency: car_arrival pulses 2 (sync) + 1 (idle detect) + DEBOUNCE_CYCLES cycles after entry_sensor rises.
// Backpressure: none; with no free slot the lane holds in FULL and lights full_lamp until a slot frees.
// Optional statistics counter enabled by defining PARKING_ENTRY_STATS_EN.
module parking_entry_gate #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int OPEN_TIMEOUT    = 16,
  parameter int CNT_W           = 8
) (
  input  logic                 clock,
  input  logic                 gl_reset,
  parking_entry_gate_if.slave  gate_if
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    REQUEST  = 3'd2,
    OPEN     = 3'd3,
    PASSING  = 3'd4,
    CLEAR    = 3'd5,
    FULL     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       es_sync_q, es_sync_d;
  logic [1:0]       ps_sync_q, ps_sync_d;
  logic             car_arrival_q, car_arrival_d;
  logic             gate_open_q, gate_open_d;
  logic             full_lamp_q, full_lamp_d;
  logic             entry_timeout_q, entry_timeout_d;
  logic             entered_d;

  logic es;
  logic ps;

  // Two-flop synchronisers; the FSM only ever looks at the second stage.
  assign es_sync_d = {es_sync_q[0], gate_if.entry_sensor};
  assign ps_sync_d = {ps_sync_q[0], gate_if.pass_sensor};
  assign es        = es_sync_q[1];
  assign ps        = ps_sync_q[1];

  // Next-state logic; outputs are derived from the next state so they register with it (Moore).
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    entry_timeout_d = 1'b0;
    entered_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (es) begin
          state_d = DEBOUNCE;
          timer_d = '0;
        end
      end
      DEBOUNCE: begin
        if (!es) begin
          state_d = IDLE;
        end else if (timer_q == DB_LAST) begin
          state_d = (gate_if.available_slots == 3'd0) ? FULL : REQUEST;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      REQUEST: begin
        // One-cycle state, so car_arrival can never be high two cycles running.
        state_d = OPEN;
        timer_d = '0;
      end
      OPEN: begin
        // A pass seen on the timeout cycle wins over the timeout.
        if (ps) begin
          state_d = PASSING;
        end else if (timer_q == OPEN_LAST) begin
          state_d         = CLEAR;
          entry_timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PASSING: begin
        if (!ps) begin
          state_d   = CLEAR;
          entered_d = 1'b1;
        end
      end
      CLEAR: begin
        // Hold here until the lane sensor drops so the same car is not counted twice.
        if (!es) state_d = IDLE;
      end
      FULL: begin
        if (!es) begin
          state_d = IDLE;
        end else if (gate_if.available_slots != 3'd0) begin
          state_d = REQUEST;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    car_arrival_d = (state_d == REQUEST);
    gate_open_d   = (state_d == OPEN) || (state_d == PASSING);
    full_lamp_d   = (state_d == FULL);
  end

  // FSM, timer, synchronisers and registered outputs; reset closes the gate immediately.
  always_ff @(posedge clock or posedge gl_reset) begin
    if (gl_reset) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      es_sync_q       <= '0;
      ps_sync_q       <= '0;
      car_arrival_q   <= 1'b0;
      gate_open_q     <= 1'b0;
      full_lamp_q     <= 1'b0;
      entry_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      es_sync_q       <= es_sync_d;
      ps_sync_q       <= ps_sync_d;
      car_arrival_q   <= car_arrival_d;
      gate_open_q     <= gate_open_d;
      full_lamp_q     <= full_lamp_d;
      entry_timeout_q <= entry_timeout_d;
    end
  end

  assign gate_if.car_arrival   = car_arrival_q;
  assign gate_if.gate_open     = gate_open_q;
  assign gate_if.full_lamp     = full_lamp_q;
  assign gate_if.entry_timeout = entry_timeout_q;

`ifdef PARKING_ENTRY_STATS_EN
  logic [CNT_W-1:0] cars_entered_q, cars_entered_d;

  // Saturating count of completed entries; only gl_reset clears it.
  always_comb begin
    cars_entered_d = cars_entered_q;
    if (entered_d && (cars_entered_q != {CNT_W{1'b1}})) begin
      cars_entered_d = cars_entered_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge gl_reset) begin
    if (gl_reset) begin
      cars_entered_q <= '0;
    end else begin
      cars_entered_q <= cars_entered_d;
    end
  end

  assign gate_if.cars_entered = cars_entered_q;
`else
  logic unused_entered;
  assign unused_entered       = entered_d;
  assign gate_if.cars_entered = '0;
`endif

endmodule

// File: tb/tb_parking_entry_gate.sv
// Directed bench for parking_entry_gate: debounce, full lane, timeout, async reset, counter saturation.
// Latency: inputs driven and outputs sampled 1 time unit after each rising clock edge.
// Backpressure: none; all stimulus is fixed-length, so the run always terminates.
module tb_parking_entry_gate;

  logic clock    = 1'b0;
  logic gl_reset = 1'b1;

  int checks = 0;
  int errors = 0;

`ifdef PARKING_ENTRY_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clock = ~clock;

  parking_entry_gate_if #(.CNT_W(8)) gif ();

  parking_entry_gate #(
    .DEBOUNCE_CYCLES(4),
    .OPEN_TIMEOUT   (16),
    .CNT_W          (8)
  ) dut (
    .clock   (clock),
    .gl_reset(gl_reset),
    .gate_if (gif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [31:0] exp_cars(input int n);
    if (!STATS) return 32'd0;
    return (n > 255) ? 32'd255 : 32'(n);
  endfunction

  // One complete car: request, open, pass, clear, back to IDLE (16 cycles).
  task automatic do_entry;
    gif.entry_sensor = 1'b1;
    tick(8);
    gif.pass_sensor = 1'b1;
    tick(3);
    gif.entry_sensor = 1'b0;
    gif.pass_sensor  = 1'b0;
    tick(5);
  endtask

  initial begin
    int seen;
    int gate_cnt;
    int to_cnt;
    int arr_cnt;
    int first_gate;
    int to_idx;

    gif.entry_sensor    = 1'b0;
    gif.pass_sensor     = 1'b0;
    gif.available_slots = 3'd7;

    // Reset state
    #12;
    chk("rst_gate",    32'(gif.gate_open), 0);
    chk("rst_arrival", 32'(gif.car_arrival), 0);
    chk("rst_full",    32'(gif.full_lamp), 0);
    chk("rst_timeout", 32'(gif.entry_timeout), 0);
    chk("rst_cars",    32'(gif.cars_entered), 0);
    @(posedge clock);
    #1;
    gl_reset = 1'b0;
    tick(2);

    // 1: normal entry
    gif.entry_sensor = 1'b1;
    tick(6);
    chk("t1_arrival_early", 32'(gif.car_arrival), 0);
    tick(1);
    chk("t1_arrival_pulse", 32'(gif.car_arrival), 1);
    chk("t1_gate_closed_req", 32'(gif.gate_open), 0);
    tick(1);
    chk("t1_arrival_single", 32'(gif.car_arrival), 0);
    chk("t1_gate_open", 32'(gif.gate_open), 1);
    tick(2);
    gif.pass_sensor = 1'b1;
    tick(3);
    chk("t1_gate_passing", 32'(gif.gate_open), 1);
    gif.entry_sensor = 1'b0;
    gif.pass_sensor  = 1'b0;
    tick(2);
    chk("t1_gate_still_open", 32'(gif.gate_open), 1);
    tick(1);
    chk("t1_gate_closed", 32'(gif.gate_open), 0);
    chk("t1_cars", 32'(gif.cars_entered), exp_cars(1));
    tick(3);

    // 2: short glitch must not trigger
    gif.entry_sensor = 1'b1;
    tick(3);
    gif.entry_sensor = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (gif.car_arrival || gif.gate_open || gif.full_lamp) seen++;
    end
    chk("t2_glitch_quiet", 32'(seen), 0);

    // 3: lane full, then a slot frees
    gif.available_slots = 3'd0;
    gif.entry_sensor    = 1'b1;
    tick(7);
    chk("t3_full_lamp", 32'(gif.full_lamp), 1);
    chk("t3_no_arrival", 32'(gif.car_arrival), 0);
    tick(3);
    chk("t3_full_hold", 32'(gif.full_lamp), 1);
    chk("t3_gate_closed", 32'(gif.gate_open), 0);
    gif.available_slots = 3'd1;
    tick(1);
    chk("t3_arrival_pulse", 32'(gif.car_arrival), 1);
    chk("t3_full_off", 32'(gif.full_lamp), 0);
    tick(1);
    chk("t3_gate_open", 32'(gif.gate_open), 1);
    chk("t3_arrival_single", 32'(gif.car_arrival), 0);
    gif.entry_sensor = 1'b0;
    tick(20);
    chk("t3_gate_closed_end", 32'(gif.gate_open), 0);
    gif.available_slots = 3'd7;

    // 4: no pass -> timeout after 16 open cycles, stays closed while car present
    gif.entry_sensor = 1'b1;
    gate_cnt   = 0;
    to_cnt     = 0;
    arr_cnt    = 0;
    first_gate = -1;
    to_idx     = -1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (gif.gate_open) begin
        gate_cnt++;
        if (first_gate < 0) first_gate = i;
      end
      if (gif.entry_timeout) begin
        to_cnt++;
        to_idx = i;
      end
      if (gif.car_arrival) arr_cnt++;
    end
    chk("t4_gate_cycles", 32'(gate_cnt), 16);
    chk("t4_first_gate", 32'(first_gate), 7);
    chk("t4_timeout_pulses", 32'(to_cnt), 1);
    chk("t4_timeout_idx", 32'(to_idx), 23);
    chk("t4_arrivals", 32'(arr_cnt), 1);
    chk("t4_gate_closed", 32'(gif.gate_open), 0);
    chk("t4_cars_unchanged", 32'(gif.cars_entered), exp_cars(1));
    gif.entry_sensor = 1'b0;
    tick(4);

    // 5: async reset while PASSING
    gif.entry_sensor = 1'b1;
    tick(8);
    gif.pass_sensor = 1'b1;
    tick(3);
    chk("t5_gate_passing", 32'(gif.gate_open), 1);
    #2;
    gl_reset = 1'b1;
    #1;
    chk("t5_gate_async", 32'(gif.gate_open), 0);
    chk("t5_arrival", 32'(gif.car_arrival), 0);
    chk("t5_full", 32'(gif.full_lamp), 0);
    chk("t5_cars", 32'(gif.cars_entered), 0);
    gif.entry_sensor = 1'b0;
    gif.pass_sensor  = 1'b0;
    @(posedge clock);
    #1;
    gl_reset = 1'b0;
    tick(2);
    chk("t5_gate_after_release", 32'(gif.gate_open), 0);

    // 6: counter saturation over 260 entries
    for (int i = 0; i < 260; i++) begin
      do_entry();
      if (i == 0)   chk("t6_cars_1", 32'(gif.cars_entered), exp_cars(1));
      if (i == 253) chk("t6_cars_254", 32'(gif.cars_entered), exp_cars(254));
      if (i == 254) chk("t6_cars_255", 32'(gif.cars_entered), exp_cars(255));
    end
    chk("t6_cars_sat", 32'(gif.cars_entered), exp_cars(260));
    chk("t6_gate_idle", 32'(gif.gate_open), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
